// File: rtl/psram_qpi_device.sv
// PSRAM device model with SPI/QPI command front end, backed by a byte memory port.
// sck is oversampled in the clk domain, so its high and low phases must each
// last at least 3 clk cycles. That leaves the prefetched byte time to land in
// rbuf before the next data nibble is driven.
module psram_qpi_device #(
  parameter int WAIT_CYCLES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sck,
  input  logic        ce_n,
  input  logic [3:0]  din,
  output logic [3:0]  dout,
  output logic        douten,
  output logic [23:0] mem_addr,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        mem_we,
  output logic [7:0]  mem_wdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WAIT, S_RDATA, S_WDATA, S_SKIP
  } state_t;

  localparam logic [7:0] CMD_QPI_EN = 8'h35;
  localparam logic [7:0] CMD_QPI_EX = 8'hF5;
  localparam logic [7:0] CMD_READ   = 8'hEB;
  localparam logic [7:0] CMD_WRITE  = 8'h38;
  localparam logic [7:0] WAIT_LAST  = 8'(WAIT_CYCLES - 1);

  state_t      state, state_d;
  logic        sck_q, rise, fall;
  logic        qpi, qpi_d;
  logic [7:0]  cmd, cmd_d, cmd_shift;
  logic [23:0] addr, addr_d;
  logic [7:0]  cnt, cnt_d;
  logic        phase, phase_d;   // nibble select within the current byte
  logic [3:0]  hold, hold_d;     // high nibble of a byte being written
  logic [7:0]  rbuf, rbuf_d;
  logic        rd_pend;          // mem_re was high last cycle, data arrives now
  logic [3:0]  dout_d;
  logic        douten_d;
  logic [23:0] mem_addr_d;
  logic        mem_re_d, mem_we_d;
  logic [7:0]  mem_wdata_d;

  assign rise = sck & ~sck_q & ~ce_n;
  assign fall = ~sck & sck_q & ~ce_n;

  // Command shift: one bit per rise in SPI, one nibble per rise in QPI.
  assign cmd_shift = qpi ? {cmd[3:0], din} : {cmd[6:0], din[0]};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next-state and next-value logic for the datapath and memory strobes.
  always_comb begin
    state_d     = state;
    qpi_d       = qpi;
    cmd_d       = cmd;
    addr_d      = addr;
    cnt_d       = cnt;
    phase_d     = phase;
    hold_d      = hold;
    rbuf_d      = rd_pend ? mem_rdata : rbuf;
    dout_d      = dout;
    douten_d    = douten;
    mem_addr_d  = mem_addr;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata;

    case (state)
      S_IDLE: begin
        if (!ce_n) begin
          state_d = S_CMD;
          cnt_d   = '0;
          cmd_d   = '0;
          phase_d = 1'b0;
        end
      end
      S_CMD: begin
        if (rise) begin
          cmd_d = cmd_shift;
          cnt_d = cnt + 8'd1;
          if (cnt == (qpi ? 8'd1 : 8'd7)) begin
            cnt_d   = '0;
            state_d = S_SKIP;
            if (!qpi && cmd_shift == CMD_QPI_EN)     qpi_d = 1'b1;
            else if (qpi && cmd_shift == CMD_QPI_EX) qpi_d = 1'b0;
            else if (qpi && (cmd_shift == CMD_READ || cmd_shift == CMD_WRITE))
              state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (rise) begin
          addr_d = {addr[19:0], din};
          cnt_d  = cnt + 8'd1;
          if (cnt == 8'd5) begin
            cnt_d   = '0;
            phase_d = 1'b0;
            state_d = (cmd == CMD_READ) ? S_WAIT : S_WDATA;
          end
        end
      end
      S_WAIT: begin
        if (rise) begin
          cnt_d = cnt + 8'd1;
          if (cnt == WAIT_LAST) begin
            cnt_d      = '0;
            mem_re_d   = 1'b1;
            mem_addr_d = addr;
            phase_d    = 1'b0;
            state_d    = S_RDATA;
          end
        end
      end
      S_RDATA: begin
        if (fall) begin
          dout_d   = phase ? rbuf[3:0] : rbuf[7:4];
          douten_d = 1'b1;
          phase_d  = ~phase;
          // Low nibble out: prefetch the next byte so it is ready for the next fall.
          if (phase) begin
            addr_d     = addr + 24'd1;
            mem_re_d   = 1'b1;
            mem_addr_d = addr + 24'd1;
          end
        end
      end
      S_WDATA: begin
        if (rise) begin
          if (!phase) begin
            hold_d  = din;
            phase_d = 1'b1;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr;
            mem_wdata_d = {hold, din};
            addr_d      = addr + 24'd1;
            phase_d     = 1'b0;
          end
        end
      end
      default: ;  // S_SKIP: ignore traffic until ce_n rises
    endcase

    // ce_n high aborts whatever is in flight; a half-written byte is dropped.
    if (ce_n) state_d = S_IDLE;
    if (state_d != S_RDATA) douten_d = 1'b0;
  end

  // Datapath, sck sampler and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_q     <= 1'b0;
      qpi       <= 1'b0;
      cmd       <= '0;
      addr      <= '0;
      cnt       <= '0;
      phase     <= 1'b0;
      hold      <= '0;
      rbuf      <= '0;
      rd_pend   <= 1'b0;
      dout      <= '0;
      douten    <= 1'b0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      sck_q     <= sck;
      qpi       <= qpi_d;
      cmd       <= cmd_d;
      addr      <= addr_d;
      cnt       <= cnt_d;
      phase     <= phase_d;
      hold      <= hold_d;
      rbuf      <= rbuf_d;
      rd_pend   <= mem_re;
      dout      <= dout_d;
      douten    <= douten_d;
      mem_addr  <= mem_addr_d;
      mem_re    <= mem_re_d;
      mem_we    <= mem_we_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_psram_qpi_device.sv
// Bench for psram_qpi_device: randomized SPI/QPI transactions against a byte-array model.
module tb_psram_qpi_device;

  localparam int WAIT_CYCLES = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        ce_n = 1'b1;
  logic [3:0]  din = 4'h0;
  logic [3:0]  dout;
  logic        douten;
  logic [23:0] mem_addr;
  logic        mem_re;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_we;
  logic [7:0]  mem_wdata;

  psram_qpi_device #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .ce_n(ce_n), .din(din),
    .dout(dout), .douten(douten), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed { logic [23:0] a; logic [7:0] d; } wr_t;
  typedef logic [7:0] byte_q_t [$];
  typedef logic [3:0] nib_q_t [$];

  logic [7:0] fix_mem [bit [23:0]];   // backing store the DUT talks to
  logic [7:0] ref_mem [bit [23:0]];   // what the bench expects memory to hold
  wr_t        wq [$];
  int         re_cnt = 0, we_cnt = 0, both_cnt = 0;
  logic [23:0] written [$];

  // Synchronous backing memory: read data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) fix_mem[mem_addr] = mem_wdata;
    if (mem_re) mem_rdata <= fix_mem.exists(mem_addr) ? fix_mem[mem_addr] : 8'h00;
  end

  // Strobe logger.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin wq.push_back('{a: mem_addr, d: mem_wdata}); we_cnt++; end
      if (mem_re) re_cnt++;
      if (mem_re && mem_we) both_cnt++;
    end
  end

  function automatic logic [7:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [3:0] exp_nib(input logic [23:0] a, input int k);
    logic [7:0] b;
    b = ref_rd(a + 24'(k / 2));
    return (k % 2) ? b[3:0] : b[7:4];
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    wq.delete(); re_cnt = 0; we_cnt = 0; both_cnt = 0;
  endtask

  task automatic pulse(input logic [3:0] v, output logic [3:0] d, output logic e);
    @(negedge clk); din = v; sck = 1'b1;
    cyc(3); sck = 1'b0;
    cyc(3); d = dout; e = douten;
  endtask

  task automatic tx_begin();
    @(negedge clk); ce_n = 1'b0; cyc(2);
  endtask

  task automatic tx_end();
    @(negedge clk); ce_n = 1'b1; din = 4'h0; cyc(3);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    logic [3:0] d; logic e;
    for (int i = 7; i >= 0; i--) pulse({3'b000, b[i]}, d, e);
  endtask

  task automatic qpi_byte(input logic [7:0] b);
    logic [3:0] d; logic e;
    pulse(b[7:4], d, e); pulse(b[3:0], d, e);
  endtask

  task automatic qpi_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) qpi_byte_nib(a[i*4 +: 4]);
  endtask

  task automatic qpi_byte_nib(input logic [3:0] n);
    logic [3:0] d; logic e;
    pulse(n, d, e);
  endtask

  task automatic reset_dut();
    @(negedge clk); rst_n = 1'b0; ce_n = 1'b1; sck = 1'b0; din = 4'h0;
    cyc(3); rst_n = 1'b1; cyc(2);
  endtask

  task automatic qpi_write(input logic [23:0] a, input byte_q_t data);
    tx_begin(); qpi_byte(8'h38); qpi_addr(a);
    foreach (data[i]) qpi_byte(data[i]);
    tx_end();
  endtask

  // Read nn nibbles; counts douten misbehaviour during wait and data phases.
  task automatic qpi_read(input logic [23:0] a, input int nn, output nib_q_t got,
                          output int wait_en, output int data_dis);
    logic [3:0] d; logic e;
    got = {}; wait_en = 0; data_dis = 0;
    tx_begin(); qpi_byte(8'hEB); qpi_addr(a);
    for (int i = 0; i < WAIT_CYCLES - 1; i++) begin
      pulse(4'($urandom), d, e); if (e) wait_en++;
    end
    for (int k = 0; k < nn; k++) begin
      pulse(4'($urandom), d, e); if (!e) data_dis++;
      got.push_back(d);
    end
    tx_end();
  endtask

  task automatic test_reset();
    reset_dut();
    n_checks++; if (douten !== 1'b0)    begin n_fail++; $display("FAIL reset_douten got=%b exp=0", douten); end
    n_checks++; if (dout !== 4'h0)      begin n_fail++; $display("FAIL reset_dout got=%h exp=0", dout); end
    n_checks++; if (mem_re !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_re got=%b exp=0", mem_re); end
    n_checks++; if (mem_we !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    n_checks++; if (mem_addr !== 24'h0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    n_checks++; if (mem_wdata !== 8'h0) begin n_fail++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
  endtask

  task automatic test_enter_qpi();
    clear_log();
    tx_begin(); spi_byte(8'h35); tx_end();
    n_checks++; if (we_cnt + re_cnt !== 0) begin n_fail++; $display("FAIL enter_qpi_strobes got=%0d exp=0", we_cnt + re_cnt); end
  endtask

  task automatic check_writes(input string name, input wr_t exp [$]);
    n_checks++;
    if (wq.size() !== exp.size()) begin
      n_fail++; $display("FAIL %s_count got=%0d exp=%0d", name, wq.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        n_checks++;
        if (wq[i] !== exp[i]) begin
          n_fail++; $display("FAIL %s_wr%0d got=%h/%h exp=%h/%h", name, i, wq[i].a, wq[i].d, exp[i].a, exp[i].d);
        end
      end
    end
  endtask

  task automatic do_write_check(input string name, input logic [23:0] a, input byte_q_t data);
    wr_t exp [$];
    clear_log();
    qpi_write(a, data);
    foreach (data[i]) begin
      exp.push_back('{a: a + 24'(i), d: data[i]});
      ref_mem[a + 24'(i)] = data[i];
      written.push_back(a + 24'(i));
    end
    check_writes(name, exp);
  endtask

  task automatic do_read_check(input string name, input logic [23:0] a, input int nn);
    nib_q_t got; int wen, dis;
    clear_log();
    qpi_read(a, nn, got, wen, dis);
    n_checks++; if (wen !== 0) begin n_fail++; $display("FAIL %s_douten_wait got=%0d exp=0", name, wen); end
    n_checks++; if (dis !== 0) begin n_fail++; $display("FAIL %s_douten_data got=%0d exp=0", name, dis); end
    n_checks++; if (douten !== 1'b0) begin n_fail++; $display("FAIL %s_douten_after got=%b exp=0", name, douten); end
    n_checks++; if (we_cnt !== 0) begin n_fail++; $display("FAIL %s_no_we got=%0d exp=0", name, we_cnt); end
    for (int k = 0; k < nn; k++) begin
      n_checks++;
      if (got[k] !== exp_nib(a, k)) begin
        n_fail++; $display("FAIL %s_nib%0d got=%h exp=%h", name, k, got[k], exp_nib(a, k));
      end
    end
  endtask

  task automatic test_write();
    do_write_check("write", 24'h000100, '{8'hAB, 8'hCD});
  endtask

  task automatic test_read();
    do_read_check("read", 24'h000100, 4);
  endtask

  task automatic test_wrap_write();
    byte_q_t d;
    d = '{8'($urandom), 8'($urandom)};
    do_write_check("wrap_write", 24'hFFFFFF, d);
    do_read_check("wrap_read", 24'hFFFFFF, 4);
  endtask

  task automatic test_partial();
    logic [23:0] a; logic [3:0] n0, n1, n2, d; logic e; wr_t exp [$];
    a = 24'($urandom); n0 = 4'($urandom); n1 = 4'($urandom); n2 = 4'($urandom);
    clear_log();
    tx_begin(); qpi_byte(8'h38); qpi_addr(a);
    pulse(n0, d, e); pulse(n1, d, e); pulse(n2, d, e);
    tx_end();
    exp.push_back('{a: a, d: {n0, n1}});
    ref_mem[a] = {n0, n1}; written.push_back(a);
    check_writes("partial", exp);
    do_read_check("partial_read", a, 2);
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 10; it++) begin
      if (($urandom_range(0, 1) == 0) || (written.size() == 0)) begin
        byte_q_t d; logic [23:0] a; int len;
        a = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF - 24'($urandom_range(0, 2)) : 24'($urandom);
        len = $urandom_range(1, 4);
        d = {};
        for (int i = 0; i < len; i++) d.push_back(8'($urandom));
        do_write_check($sformatf("rnd_wr%0d", it), a, d);
      end else begin
        do_read_check($sformatf("rnd_rd%0d", it), written[$urandom_range(0, written.size() - 1)],
                      $urandom_range(1, 6));
      end
    end
    n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL re_we_overlap got=%0d exp=0", both_cnt); end
  endtask

  task automatic test_spi_eb();
    logic [3:0] d; logic e; int en_seen;
    reset_dut(); clear_log(); en_seen = 0;
    tx_begin(); spi_byte(8'hEB);
    for (int i = 0; i < 12; i++) begin pulse(4'($urandom), d, e); if (e) en_seen++; end
    tx_end();
    n_checks++; if (we_cnt + re_cnt !== 0) begin n_fail++; $display("FAIL spi_eb_strobes got=%0d exp=0", we_cnt + re_cnt); end
    n_checks++; if (en_seen !== 0) begin n_fail++; $display("FAIL spi_eb_douten got=%0d exp=0", en_seen); end
  endtask

  task automatic test_reset_mid_read();
    logic [3:0] d; logic e; int en_seen;
    tx_begin(); spi_byte(8'h35); tx_end();
    tx_begin(); qpi_byte(8'hEB); qpi_addr(24'h000100);
    for (int i = 0; i < WAIT_CYCLES + 2; i++) pulse(4'h0, d, e);
    @(negedge clk); rst_n = 1'b0; cyc(3);
    clear_log(); rst_n = 1'b1; en_seen = 0;
    // Controller keeps clocking; the device now sees an SPI command of 0x00.
    for (int i = 0; i < 10; i++) begin pulse(4'hE, d, e); if (e) en_seen++; end
    tx_end();
    n_checks++; if (we_cnt + re_cnt !== 0) begin n_fail++; $display("FAIL rst_mid_strobes got=%0d exp=0", we_cnt + re_cnt); end
    n_checks++; if (en_seen !== 0 || douten !== 1'b0) begin n_fail++; $display("FAIL rst_mid_douten got=%0d exp=0", en_seen); end
    // A QPI-formatted write must be ignored because the device is back in SPI mode.
    clear_log();
    qpi_write(24'h000000, '{8'h5A, 8'hA5});
    n_checks++; if (we_cnt !== 0) begin n_fail++; $display("FAIL rst_mid_qpi_cleared got=%0d exp=0", we_cnt); end
  endtask

  initial begin
    test_reset();
    test_enter_qpi();
    test_write();
    test_read();
    test_wrap_write();
    test_partial();
    test_back_to_back();
    test_spi_eb();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
